// File: rtl/id_stage.sv
// Instruction decode stage: register file, busy scoreboard, decode of OP/OP-IMM,
// and a single-entry valid/ready output register toward execute.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  output logic        if_ready,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_rs1_val,
  output logic [31:0] ex_rs2_val,
  output logic [2:0]  ex_funct3,
  output logic [11:0] ex_imm_i,
  output logic [4:0]  ex_rd,
  output logic        ex_op,
  output logic        ex_op_imm,
  output logic        ex_illegal,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        flush
);

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] F7Zero   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;

  logic [31:0] rf_q [32];
  logic [31:0] busy_q, busy_d;
  logic        rst_done_q;

  logic        ex_valid_q;
  logic [31:0] ex_rs1_val_q, ex_rs2_val_q;
  logic [2:0]  ex_funct3_q;
  logic [11:0] ex_imm_i_q;
  logic [4:0]  ex_rd_q;
  logic        ex_op_q, ex_op_imm_q, ex_illegal_q;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [11:0] imm_i;
  logic        is_op, is_op_imm, illegal;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] wb_clr, busy_eff;
  logic        hazard, load;

  assign opcode    = if_instr[6:0];
  assign rd        = if_instr[11:7];
  assign funct3    = if_instr[14:12];
  assign rs1       = if_instr[19:15];
  assign rs2       = if_instr[24:20];
  assign funct7    = if_instr[31:25];
  assign imm_i     = if_instr[31:20];
  assign is_op     = (opcode == OpcOp);
  assign is_op_imm = (opcode == OpcOpImm);

  always_comb begin
    illegal = 1'b1;
    if (is_op) begin
      illegal = !((funct7 == F7Zero) ||
                  ((funct7 == F7Alt) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
    end else if (is_op_imm) begin
      // Shift-immediate forms reuse imm[11:5] as a funct7 field.
      unique case (funct3)
        3'b001:  illegal = (funct7 != F7Zero);
        3'b101:  illegal = !((funct7 == F7Zero) || (funct7 == F7Alt));
        default: illegal = 1'b0;
      endcase
    end
  end

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0) rs1_val = (wb_en && (wb_rd == rs1)) ? wb_data : rf_q[rs1];
    if (rs2 != 5'd0) rs2_val = (wb_en && (wb_rd == rs2)) ? wb_data : rf_q[rs2];
  end

  assign wb_clr   = wb_en ? (32'd1 << wb_rd) : 32'd0;
  assign busy_eff = busy_q & ~wb_clr;
  assign hazard   = !illegal &&
                    (busy_eff[rs1] || (is_op && busy_eff[rs2]) || busy_eff[rd]);

  assign if_ready = rst_done_q & !flush & !hazard & (!ex_valid_q | ex_ready);
  assign load     = if_valid & if_ready;

  always_comb begin
    busy_d = busy_q & ~wb_clr;
    if (flush && ex_valid_q && !ex_illegal_q) busy_d[ex_rd_q] = 1'b0;
    // A new claim on rd wins over a writeback retiring the same register.
    if (load && !illegal) busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_en && (wb_rd != 5'd0)) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      rst_done_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      rst_done_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_rs1_val_q <= '0;
      ex_rs2_val_q <= '0;
      ex_funct3_q  <= '0;
      ex_imm_i_q   <= '0;
      ex_rd_q      <= '0;
      ex_op_q      <= 1'b0;
      ex_op_imm_q  <= 1'b0;
      ex_illegal_q <= 1'b0;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
    end else if (load) begin
      ex_valid_q   <= 1'b1;
      ex_rs1_val_q <= rs1_val;
      ex_rs2_val_q <= rs2_val;
      ex_funct3_q  <= funct3;
      ex_imm_i_q   <= imm_i;
      ex_rd_q      <= rd;
      ex_op_q      <= is_op;
      ex_op_imm_q  <= is_op_imm;
      ex_illegal_q <= illegal;
    end else if (ex_ready) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_rs1_val = ex_rs1_val_q;
  assign ex_rs2_val = ex_rs2_val_q;
  assign ex_funct3  = ex_funct3_q;
  assign ex_imm_i   = ex_imm_i_q;
  assign ex_rd      = ex_rd_q;
  assign ex_op      = ex_op_q;
  assign ex_op_imm  = ex_op_imm_q;
  assign ex_illegal = ex_illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: reference register-file model feeding a scoreboard of
// expected decode packets, plus directed handshake/hazard/flush/reset checks.
module tb_id_stage;

  localparam logic [6:0] OpcOpImm = 7'b0010011;

  typedef struct packed {
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [2:0]  funct3;
    logic [11:0] imm;
    logic [4:0]  rd;
    logic        op;
    logic        op_imm;
    logic        illegal;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_ready, ex_valid, ex_ready;
  logic [31:0] if_instr;
  logic [31:0] ex_rs1_val, ex_rs2_val;
  logic [2:0]  ex_funct3;
  logic [11:0] ex_imm_i;
  logic [4:0]  ex_rd;
  logic        ex_op, ex_op_imm, ex_illegal;
  logic        wb_en, flush;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  pkt_t        sb[$];
  logic [31:0] rf_m [32];
  logic        cur_illegal;
  int          n_chk = 0;
  int          n_bad = 0;
  logic [31:0] tbl_instr [8];
  logic        tbl_ill [8];

  always #5 clk = ~clk;

  id_stage dut (
    .clk       (clk),
    .rst       (rst),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .if_ready  (if_ready),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_rs1_val(ex_rs1_val),
    .ex_rs2_val(ex_rs2_val),
    .ex_funct3 (ex_funct3),
    .ex_imm_i  (ex_imm_i),
    .ex_rd     (ex_rd),
    .ex_op     (ex_op),
    .ex_op_imm (ex_op_imm),
    .ex_illegal(ex_illegal),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .flush     (flush)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] rd_model(logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_en && (wb_rd == r)) return wb_data;
    return rf_m[r];
  endfunction

  task automatic issue(input logic [31:0] instr, input logic ill);
    if_valid    = 1'b1;
    if_instr    = instr;
    cur_illegal = ill;
  endtask

  // One clock: sample at the falling edge, then advance past the rising edge.
  task automatic tick();
    pkt_t e;
    @(negedge clk);
    if (flush && ex_valid) begin
      if (sb.size() != 0) e = sb.pop_front();
    end else if (ex_valid && ex_ready) begin
      check_eq("sb_has_exp", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("rs1_val", ex_rs1_val, e.rs1_val);
        check_eq("rs2_val", ex_rs2_val, e.rs2_val);
        check_eq("funct3", 32'(ex_funct3), 32'(e.funct3));
        check_eq("imm_i", 32'(ex_imm_i), 32'(e.imm));
        check_eq("rd", 32'(ex_rd), 32'(e.rd));
        check_eq("op", 32'(ex_op), 32'(e.op));
        check_eq("op_imm", 32'(ex_op_imm), 32'(e.op_imm));
        check_eq("illegal", 32'(ex_illegal), 32'(e.illegal));
      end
    end
    if (if_valid && if_ready) begin
      e.rs1_val = rd_model(if_instr[19:15]);
      e.rs2_val = rd_model(if_instr[24:20]);
      e.funct3  = if_instr[14:12];
      e.imm     = if_instr[31:20];
      e.rd      = if_instr[11:7];
      e.op      = (if_instr[6:0] == 7'b0110011);
      e.op_imm  = (if_instr[6:0] == OpcOpImm);
      e.illegal = cur_illegal;
      sb.push_back(e);
    end
    @(posedge clk);
    if (wb_en && (wb_rd != 5'd0)) rf_m[wb_rd] = wb_data;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    tbl_instr[0] = enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd0); tbl_ill[0] = 1'b0;
    tbl_instr[1] = enc_r(7'b0100000, 5'd2, 5'd1, 3'b001, 5'd0); tbl_ill[1] = 1'b1;
    tbl_instr[2] = enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd0); tbl_ill[2] = 1'b1;
    tbl_instr[3] = enc_i({7'b0100000, 5'd5}, 5'd1, 3'b101, 5'd0, OpcOpImm); tbl_ill[3] = 1'b0;
    tbl_instr[4] = enc_i({7'b0010000, 5'd5}, 5'd1, 3'b101, 5'd0, OpcOpImm); tbl_ill[4] = 1'b1;
    tbl_instr[5] = enc_i(12'hFFF, 5'd1, 3'b111, 5'd0, OpcOpImm); tbl_ill[5] = 1'b0;
    tbl_instr[6] = enc_i(12'h000, 5'd1, 3'b000, 5'd0, 7'b1100011); tbl_ill[6] = 1'b1;
    tbl_instr[7] = enc_i({7'b0000001, 5'd1}, 5'd1, 3'b001, 5'd0, OpcOpImm); tbl_ill[7] = 1'b1;

    rst = 1'b1; if_valid = 1'b0; if_instr = '0; ex_ready = 1'b0; cur_illegal = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ex_valid", 32'(ex_valid), 32'd0);
    check_eq("rst_if_ready", 32'(if_ready), 32'd0);
    check_eq("rst_rs1_val", ex_rs1_val, 32'd0);
    check_eq("rst_rd", 32'(ex_rd), 32'd0);
    rst = 1'b0;
    #1 check_eq("rdy_before_edge", 32'(if_ready), 32'd0);
    @(posedge clk); #1;
    check_eq("rdy_after_edge", 32'(if_ready), 32'd1);

    // Write x5, then addi x6,x5,3 followed immediately by add x7,x6,x6.
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_0010;
    tick();
    wb_en = 1'b0;
    ex_ready = 1'b1;
    issue(enc_i(12'd3, 5'd5, 3'b000, 5'd6, OpcOpImm), 1'b0);
    tick();
    issue(enc_r(7'b0, 5'd6, 5'd6, 3'b000, 5'd7), 1'b0);
    #1;
    check_eq("addi_ex_valid", 32'(ex_valid), 32'd1);
    check_eq("raw_stall_0", 32'(if_ready), 32'd0);
    tick();
    check_eq("raw_stall_1", 32'(if_ready), 32'd0);
    tick();
    check_eq("raw_stall_2", 32'(if_ready), 32'd0);
    wb_en = 1'b1; wb_rd = 5'd6; wb_data = 32'h0000_0013;
    #1 check_eq("raw_release", 32'(if_ready), 32'd1);
    tick();
    wb_en = 1'b0;

    // Backpressure: held output stays put while ex_ready is low.
    issue(enc_i(12'h055, 5'd0, 3'b000, 5'd8, OpcOpImm), 1'b0);
    tick();
    ex_ready = 1'b0;
    issue(enc_i(12'h066, 5'd0, 3'b000, 5'd11, OpcOpImm), 1'b0);
    #1 check_eq("bp_rdy", 32'(if_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("bp_valid", 32'(ex_valid), 32'd1);
      check_eq("bp_rd", 32'(ex_rd), 32'd8);
      check_eq("bp_imm", 32'(ex_imm_i), 32'h055);
      check_eq("bp_rdy_hold", 32'(if_ready), 32'd0);
    end
    ex_ready = 1'b1;
    #1 check_eq("bp_release", 32'(if_ready), 32'd1);
    tick();
    if_valid = 1'b0;
    tick();
    check_eq("drain_clear", 32'(ex_valid), 32'd0);

    // Illegal instructions must not claim their rd.
    issue(enc_i(12'h004, 5'd0, 3'b010, 5'd12, 7'b0000011), 1'b1);
    tick();
    issue({7'b0100000, 5'd3, 5'd1, 3'b001, 5'd13, OpcOpImm}, 1'b1);
    tick();
    issue(enc_r(7'b0, 5'd13, 5'd12, 3'b000, 5'd14), 1'b0);
    #1 check_eq("ill_no_stall", 32'(if_ready), 32'd1);
    tick();
    if_valid = 1'b0;
    tick();

    // Legality table, with nonzero operand values in x1/x2.
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'hA5A5_0001;
    tick();
    wb_rd = 5'd2; wb_data = 32'h0F0F_0002;
    tick();
    wb_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      issue(tbl_instr[i], tbl_ill[i]);
      #1 check_eq("tbl_rdy", 32'(if_ready), 32'd1);
      tick();
    end
    if_valid = 1'b0;
    tick();

    // Flush of a held writer of x9 releases x9 at once.
    ex_ready = 1'b0;
    issue(enc_i(12'd7, 5'd0, 3'b000, 5'd9, OpcOpImm), 1'b0);
    tick();
    if_valid = 1'b0;
    flush = 1'b1;
    #1 check_eq("flush_rdy", 32'(if_ready), 32'd0);
    tick();
    flush = 1'b0;
    issue(enc_r(7'b0, 5'd9, 5'd9, 3'b000, 5'd15), 1'b0);
    #1;
    check_eq("flush_ex_valid", 32'(ex_valid), 32'd0);
    check_eq("flush_reader_rdy", 32'(if_ready), 32'd1);
    ex_ready = 1'b1;
    tick();
    if_valid = 1'b0;
    tick();

    // Reset in the middle of a stall with busy bits outstanding.
    issue(enc_r(7'b0, 5'd1, 5'd15, 3'b000, 5'd16), 1'b0);
    #1 check_eq("pre_rst_stall", 32'(if_ready), 32'd0);
    tick();
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", 32'(ex_valid), 32'd0);
    check_eq("mid_rst_rdy", 32'(if_ready), 32'd0);
    check_eq("mid_rst_rs1", ex_rs1_val, 32'd0);
    if_valid = 1'b0;
    sb.delete();
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    issue(enc_r(7'b0, 5'd7, 5'd15, 3'b000, 5'd0), 1'b0);
    #1 check_eq("post_rst_no_busy", 32'(if_ready), 32'd1);
    tick();
    for (int r = 1; r < 32; r++) begin
      issue(enc_r(7'b0, 5'(r), 5'(r), 3'b000, 5'd0), 1'b0);
      #1 check_eq("post_rst_rdy", 32'(if_ready), 32'd1);
      tick();
    end
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
    issue(enc_r(7'b0, 5'd0, 5'd0, 3'b000, 5'd0), 1'b0);
    tick();
    wb_en = 1'b0;
    tick();
    if_valid = 1'b0;
    tick();
    tick();
    check_eq("sb_drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
